// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the output-stationary systolic MAC engine.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH,
    DRAIN
  } state_e;

  // Cycles for the last skewed operand to reach the far-corner PE and be accumulated.
  function automatic int flush_len(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/os_pe.sv
// One output-stationary processing element: registered A/B pass-through plus a
// wrapping accumulator fed by a signed or unsigned product.
module os_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [ACC_W-1:0]  acc_o
);

  logic [DATA_W-1:0]          a_q, b_q;
  logic [ACC_W-1:0]           acc_q;
  logic [2*DATA_W-1:0]        prodU;
  logic signed [2*DATA_W-1:0] prodS;
  logic [ACC_W-1:0]           addend;

  assign prodU  = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
  assign prodS  = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i}) * $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});
  // The size cast sign-extends prodS because it is declared signed.
  assign addend = signed_i ? ACC_W'(prodS) : ACC_W'(prodU);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q <= a_i;
      b_q <= b_i;
      if (clr_i) acc_q <= '0;
      else       acc_q <= acc_q + addend;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_mac_engine.sv
// Tile-level systolic matrix multiplier: operand skew lines, a ROWSxCOLS grid of
// output-stationary PEs, and a FEED/FLUSH/DRAIN controller streaming rows of C.
module systolic_mac_engine
  import systolic_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int K_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [K_W-1:0]         i_k_len,
  input  logic                   i_signed,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [ROWS*DATA_W-1:0] a_data,
  input  logic [COLS*DATA_W-1:0] b_data,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [COLS*ACC_W-1:0]  o_data,
  output logic                   o_last,
  output logic                   o_busy
);

  localparam int FLUSH_LEN = flush_len(ROWS, COLS);
  localparam int FL_W      = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_e                 state_q, state_d;
  logic [K_W-1:0]         kCnt_q, kCnt_d;
  logic [K_W-1:0]         kLen_q, kLen_d;
  logic                   signed_q, signed_d;
  logic [FL_W-1:0]        flushCnt_q, flushCnt_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic                   oValid_q, oValid_d;
  logic                   oLast_q, oLast_d;
  logic [COLS*ACC_W-1:0]  oData_q, oData_d;
  logic                   clrAcc;
  logic                   xfer;

  logic [DATA_W-1:0]      aFeed [ROWS];
  logic [DATA_W-1:0]      bFeed [COLS];
  logic [DATA_W-1:0]      aPipe [ROWS][COLS+1];
  logic [DATA_W-1:0]      bPipe [ROWS+1][COLS];
  logic [ACC_W-1:0]       acc   [ROWS][COLS];
  logic [COLS*ACC_W-1:0]  rowData [ROWS];
  logic [ROWS-1:0]        unusedA;
  logic [COLS-1:0]        unusedB;

  assign xfer = a_valid && (state_q == FEED);

  // Idle cycles inject zeros so stalls never disturb the skew alignment.
  for (genvar r = 0; r < ROWS; r++) begin : g_row_skew
    assign aFeed[r] = xfer ? a_data[r*DATA_W +: DATA_W] : '0;
    if (r == 0) begin : g_direct
      assign aPipe[r][0] = aFeed[r];
    end else begin : g_dly
      logic [DATA_W-1:0] sr_q [r];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < r; i++) sr_q[i] <= '0;
        end else begin
          sr_q[0] <= aFeed[r];
          for (int i = 1; i < r; i++) sr_q[i] <= sr_q[i-1];
        end
      end
      assign aPipe[r][0] = sr_q[r-1];
    end
    assign unusedA[r] = ^aPipe[r][COLS];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col_skew
    assign bFeed[c] = xfer ? b_data[c*DATA_W +: DATA_W] : '0;
    if (c == 0) begin : g_direct
      assign bPipe[0][c] = bFeed[c];
    end else begin : g_dly
      logic [DATA_W-1:0] sr_q [c];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < c; i++) sr_q[i] <= '0;
        end else begin
          sr_q[0] <= bFeed[c];
          for (int i = 1; i < c; i++) sr_q[i] <= sr_q[i-1];
        end
      end
      assign bPipe[0][c] = sr_q[c-1];
    end
    assign unusedB[c] = ^bPipe[ROWS][c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe_col
      os_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (clrAcc),
        .signed_i (signed_q),
        .a_i      (aPipe[r][c]),
        .b_i      (bPipe[r][c]),
        .a_o      (aPipe[r][c+1]),
        .b_o      (bPipe[r+1][c]),
        .acc_o    (acc[r][c])
      );
    end
  end

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      rowData[r] = '0;
      for (int c = 0; c < COLS; c++) rowData[r][c*ACC_W +: ACC_W] = acc[r][c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      kCnt_q     <= '0;
      kLen_q     <= '0;
      signed_q   <= 1'b0;
      flushCnt_q <= '0;
      row_q      <= '0;
      oValid_q   <= 1'b0;
      oLast_q    <= 1'b0;
      oData_q    <= '0;
    end else begin
      state_q    <= state_d;
      kCnt_q     <= kCnt_d;
      kLen_q     <= kLen_d;
      signed_q   <= signed_d;
      flushCnt_q <= flushCnt_d;
      row_q      <= row_d;
      oValid_q   <= oValid_d;
      oLast_q    <= oLast_d;
      oData_q    <= oData_d;
    end
  end

  // The output register is loaded on the last FLUSH cycle so o_valid rises with DRAIN.
  always_comb begin
    state_d    = state_q;
    kCnt_d     = kCnt_q;
    kLen_d     = kLen_q;
    signed_d   = signed_q;
    flushCnt_d = flushCnt_q;
    row_d      = row_q;
    oValid_d   = oValid_q;
    oLast_d    = oLast_q;
    oData_d    = oData_q;
    clrAcc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start && (i_k_len != '0)) begin
          state_d  = FEED;
          kCnt_d   = '0;
          kLen_d   = i_k_len;
          signed_d = i_signed;
          clrAcc   = 1'b1;
        end
      end
      FEED: begin
        if (xfer) begin
          if (kCnt_q == kLen_q - K_W'(1)) begin
            state_d    = FLUSH;
            flushCnt_d = '0;
          end else begin
            kCnt_d = kCnt_q + K_W'(1);
          end
        end
      end
      FLUSH: begin
        if (flushCnt_q == FL_W'(FLUSH_LEN - 1)) begin
          state_d  = DRAIN;
          row_d    = '0;
          oValid_d = 1'b1;
          oData_d  = rowData[0];
          oLast_d  = (ROWS == 1);
        end else begin
          flushCnt_d = flushCnt_q + FL_W'(1);
        end
      end
      DRAIN: begin
        if (o_ready) begin
          if (row_q == ROW_W'(ROWS - 1)) begin
            state_d  = IDLE;
            oValid_d = 1'b0;
            oLast_d  = 1'b0;
          end else begin
            row_d   = row_q + ROW_W'(1);
            oData_d = rowData[row_q + ROW_W'(1)];
            oLast_d = ((row_q + ROW_W'(1)) == ROW_W'(ROWS - 1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign a_ready = (state_q == FEED);
  assign o_busy  = (state_q != IDLE);
  assign o_valid = oValid_q;
  assign o_last  = oLast_q;
  assign o_data  = oData_q;

endmodule
